// File: rtl/legv8_encoder.sv
// Assembles symbolic LEGv8 commands into 32-bit words and streams them into instruction memory.
// Optional LEGV8_ENC_TRAP_EN: illegal ops are written as 32'h0 instead of being dropped.
module legv8_encoder #(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [3:0]        cmd_op_i,
  input  logic [4:0]        cmd_rd_i,
  input  logic [4:0]        cmd_rn_i,
  input  logic [4:0]        cmd_rm_i,
  input  logic [18:0]       cmd_imm_i,
  output logic              imem_we_o,
  input  logic              imem_ready_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              err_o
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FULL} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [ADDR_W:0]     count_q;
  logic                we_q;
  logic                full_q;
  logic                err_q;

  logic [31:0]         word_d;
  logic                illegal;
  logic                last;
  logic                acc;
  logic                wr_acc;

  always_comb begin
    word_d = 32'h0000_0000;
    case (cmd_op_i)
      4'd0: word_d = {11'h458, cmd_rm_i, 6'b0, cmd_rn_i, cmd_rd_i};
      4'd1: word_d = {11'h658, cmd_rm_i, 6'b0, cmd_rn_i, cmd_rd_i};
      4'd2: word_d = {11'h450, cmd_rm_i, 6'b0, cmd_rn_i, cmd_rd_i};
      4'd3: word_d = {11'h550, cmd_rm_i, 6'b0, cmd_rn_i, cmd_rd_i};
      4'd4: word_d = {11'h6B0, 5'b11111, 6'b0, cmd_rn_i, 5'b0};
      4'd5: word_d = 32'hD69F_03E0;
      4'd6: word_d = {11'h6A9, cmd_imm_i[15:0], cmd_rd_i};
      4'd7: word_d = {11'h7C2, cmd_imm_i[8:0], 2'b00, cmd_rn_i, cmd_rd_i};
      4'd8: word_d = {11'h7C0, cmd_imm_i[8:0], 2'b00, cmd_rn_i, cmd_rd_i};
      4'd9: word_d = {8'hB4, cmd_imm_i, cmd_rd_i};
      default: word_d = 32'h0000_0000;
    endcase
  end

  assign illegal = (cmd_op_i > 4'd9);
  assign last    = (addr_q == LAST);

  // Back-to-back accept only while the current write completes and is not the final address.
  assign cmd_ready_o = reset_i && !clear_i &&
                       ((state_q == S_IDLE) ||
                        (state_q == S_WRITE && imem_ready_i && !last));
  assign acc = cmd_valid_i && cmd_ready_o;

`ifdef LEGV8_ENC_TRAP_EN
  assign wr_acc = acc;
`else
  assign wr_acc = acc && !illegal;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      addr_q  <= BASE;
      wdata_q <= 32'h0000_0000;
      count_q <= '0;
      we_q    <= 1'b0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (clear_i) begin
      state_q <= S_IDLE;
      addr_q  <= BASE;
      count_q <= '0;
      we_q    <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      if (acc && illegal) err_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (wr_acc) begin
            wdata_q <= word_d;
            we_q    <= 1'b1;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (imem_ready_i) begin
            count_q <= count_q + (ADDR_W+1)'(1);
            addr_q  <= addr_q + ADDR_W'(1);
            if (last) begin
              we_q    <= 1'b0;
              full_q  <= 1'b1;
              state_q <= S_FULL;
            end else if (wr_acc) begin
              wdata_q <= word_d;
            end else begin
              we_q    <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          we_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign count_o      = count_q;
  assign full_o       = full_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_legv8_encoder.sv
// Scoreboarded bench for legv8_encoder with a 4-word address space.
module tb_legv8_encoder;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset, clear, cmd_valid, cmd_ready;
  logic [3:0]    cmd_op;
  logic [4:0]    cmd_rd, cmd_rn, cmd_rm;
  logic [18:0]   cmd_imm;
  logic          imem_we, imem_ready;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          full, err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [AW+31:0] sb_q[$];

  legv8_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk_i(clk), .reset_i(reset), .clear_i(clear),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_rd_i(cmd_rd), .cmd_rn_i(cmd_rn), .cmd_rm_i(cmd_rm),
    .cmd_imm_i(cmd_imm),
    .imem_we_o(imem_we), .imem_ready_i(imem_ready),
    .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
    .count_o(count), .full_o(full), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write handshake must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && imem_we && imem_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_write", {30'b0, imem_addr}, 32'hFFFF_FFFF);
        end else begin
          logic [AW+31:0] e;
          e = sb_q.pop_front();
          chk("sb_addr", {30'b0, imem_addr}, {30'b0, e[AW+31:32]});
          chk("sb_data", imem_wdata, e[31:0]);
        end
      end
    end
  end

  task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
    sb_q.push_back({a, d});
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                      input logic [4:0] rm, input logic [18:0] imm, input int max_cyc,
                      output bit acc);
    logic rdy;
    cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_imm = imm;
    cmd_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < max_cyc && !acc; k++) begin
      @(negedge clk);
      rdy = cmd_ready;
      @(posedge clk);
      acc = rdy;
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(posedge clk);
    #1 clear = 1'b1;
    @(negedge clk);
    chk("clear_forces_ready_low", {31'b0, cmd_ready}, 32'd0);
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  initial begin
    bit acc;
    reset = 1'b0; clear = 1'b0; cmd_valid = 1'b0; imem_ready = 1'b1;
    cmd_op = '0; cmd_rd = '0; cmd_rn = '0; cmd_rm = '0; cmd_imm = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_we",        {31'b0, imem_we},   32'd0);
    chk("rst_addr",      {30'b0, imem_addr}, 32'd0);
    chk("rst_wdata",     imem_wdata,         32'd0);
    chk("rst_count",     {29'b0, count},     32'd0);
    chk("rst_full",      {31'b0, full},      32'd0);
    chk("rst_err",       {31'b0, err},       32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // ADD rd=1 rn=2 rm=3, one cycle latency
    expect_wr(2'd0, 32'h8B03_0041);
    send(4'd0, 5'd1, 5'd2, 5'd3, 19'd0, 10, acc);
    chk("add_acc", {31'b0, acc}, 32'd1);
    @(negedge clk);
    chk("add_we_t1",    {31'b0, imem_we}, 32'd1);
    chk("add_wdata_t1", imem_wdata,       32'h8B03_0041);
    @(negedge clk);
    chk("add_count", {29'b0, count},   32'd1);
    chk("add_we_off", {31'b0, imem_we}, 32'd0);
    do_clear();

    // LDUR then CBZ back-to-back
    expect_wr(2'd0, 32'hF840_80C5);
    expect_wr(2'd1, 32'hB4FF_FFC0);
    send(4'd7, 5'd5, 5'd6, 5'd0, 19'd8, 10, acc);
    cmd_op = 4'd9; cmd_rd = 5'd0; cmd_rn = 5'd0; cmd_rm = 5'd0; cmd_imm = 19'h7FFFE;
    cmd_valid = 1'b1;
    @(negedge clk);
    chk("b2b_wdata0", imem_wdata,          32'hF840_80C5);
    chk("b2b_ready",  {31'b0, cmd_ready},  32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_we1",    {31'b0, imem_we},   32'd1);
    chk("b2b_wdata1", imem_wdata,         32'hB4FF_FFC0);
    chk("b2b_addr1",  {30'b0, imem_addr}, 32'd1);
    @(negedge clk);
    chk("b2b_count", {29'b0, count}, 32'd2);
    do_clear();

    // BR rn=30 with a 3-cycle stall, ERET waiting behind it
    expect_wr(2'd0, 32'hD61F_03C0);
    expect_wr(2'd1, 32'hD69F_03E0);
    imem_ready = 1'b0;
    send(4'd4, 5'd0, 5'd30, 5'd0, 19'd0, 10, acc);
    cmd_op = 4'd5; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_we",    {31'b0, imem_we},   32'd1);
      chk("stall_wdata", imem_wdata,         32'hD61F_03C0);
      chk("stall_addr",  {30'b0, imem_addr}, 32'd0);
      chk("stall_ready", {31'b0, cmd_ready}, 32'd0);
    end
    @(posedge clk);
    #1 imem_ready = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("eret_wdata", imem_wdata,         32'hD69F_03E0);
    chk("eret_addr",  {30'b0, imem_addr}, 32'd1);
    @(negedge clk);
    chk("eret_count", {29'b0, count}, 32'd2);
    do_clear();

    // Fill all 4 addresses with ORR rd=rm=i, 5th command must be refused
    for (int i = 0; i < 4; i++) begin
      expect_wr(AW'(i), 32'hAA00_0000 | (i << 16) | i);
      send(4'd3, 5'(i), 5'd0, 5'(i), 19'd0, 10, acc);
      chk("fill_acc", {31'b0, acc}, 32'd1);
    end
    @(negedge clk);
    chk("fill_last_addr",  {30'b0, imem_addr}, 32'd3);
    chk("fill_last_ready", {31'b0, cmd_ready}, 32'd0);
    chk("fill_full_early", {31'b0, full},      32'd0);
    @(negedge clk);
    chk("fill_full",  {31'b0, full},    32'd1);
    chk("fill_count", {29'b0, count},   32'd4);
    send(4'd0, 5'd1, 5'd1, 5'd1, 19'd0, 6, acc);
    chk("fifth_refused", {31'b0, acc}, 32'd0);
    chk("full_we_off", {31'b0, imem_we}, 32'd0);
    do_clear();
    @(negedge clk);
    chk("clr_count", {29'b0, count},     32'd0);
    chk("clr_addr",  {30'b0, imem_addr}, 32'd0);
    chk("clr_ready", {31'b0, cmd_ready}, 32'd1);
    chk("clr_full",  {31'b0, full},      32'd0);

    // Illegal op 12
`ifdef LEGV8_ENC_TRAP_EN
    expect_wr(2'd0, 32'h0000_0000);
`endif
    send(4'd12, 5'd1, 5'd2, 5'd3, 19'h7FFFF, 10, acc);
    chk("illegal_acc", {31'b0, acc}, 32'd1);
    @(negedge clk);
    chk("illegal_err", {31'b0, err}, 32'd1);
`ifdef LEGV8_ENC_TRAP_EN
    chk("illegal_we",  {31'b0, imem_we}, 32'd1);
    @(negedge clk);
    chk("illegal_count", {29'b0, count}, 32'd1);
`else
    chk("illegal_we",  {31'b0, imem_we}, 32'd0);
    @(negedge clk);
    chk("illegal_count", {29'b0, count}, 32'd0);
`endif
    do_clear();
    chk("err_sticky_clear", {31'b0, err}, 32'd1);

    // Remaining formats: MRS, STUR, SUB, AND
    expect_wr(2'd0, 32'hD522_4682);
    expect_wr(2'd1, 32'hF81F_F107);
    expect_wr(2'd2, 32'hCB05_0083);
    expect_wr(2'd3, 32'h8A0B_0149);
    send(4'd6, 5'd2,  5'd0,  5'd0,  19'h01234, 10, acc);
    send(4'd8, 5'd7,  5'd8,  5'd0,  19'h001FF, 10, acc);
    send(4'd1, 5'd3,  5'd4,  5'd5,  19'd0,     10, acc);
    send(4'd2, 5'd9,  5'd10, 5'd11, 19'd0,     10, acc);
    repeat (2) @(negedge clk);
    chk("fmt_full", {31'b0, full}, 32'd1);
    do_clear();

    // Reset during a stalled write
    imem_ready = 1'b0;
    send(4'd0, 5'd1, 5'd1, 5'd1, 19'd0, 10, acc);
    @(negedge clk);
    chk("pre_rst_we", {31'b0, imem_we}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cycle_ready", {31'b0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("mid_rst_we",    {31'b0, imem_we},   32'd0);
    chk("mid_rst_count", {29'b0, count},     32'd0);
    chk("mid_rst_addr",  {30'b0, imem_addr}, 32'd0);
    chk("mid_rst_wdata", imem_wdata,         32'd0);
    chk("mid_rst_err",   {31'b0, err},       32'd0);
    chk("mid_rst_full",  {31'b0, full},      32'd0);
    @(posedge clk);
    #1 reset = 1'b1; imem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_no_write", {31'b0, imem_we}, 32'd0);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/legv8_encoder.md
# legv8_encoder

Instruction encoder and program loader for the LEGv8 core: accepts symbolic instruction commands (op, register fields, immediate) over a valid/ready handshake, assembles the 32-bit LEGv8 machine word, and writes it sequentially into instruction memory through a backpressured write port. It produces the words that the main decoder consumes. It is used by bench and boot logic to load test programs, including deliberately illegal words for the NotAnInstr exception path.

## Interface
- ADDR_W, 6, instruction-memory word-address width (DEPTH = 2^ADDR_W)
- BASE_ADDR, 0, first word address written after reset/clear
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- clear  in  1  restart loading at BASE_ADDR, drop pending word
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&&ready at clk edge
- cmd_op  in  4  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 BR, 5 ERET, 6 MRS, 7 LDUR, 8 STUR, 9 CBZ, 10–15 illegal
- cmd_rd / cmd_rn / cmd_rm  in  5 each  Rd/Rt, Rn, Rm
- cmd_imm  in  19  immediate (LDUR/STUR [8:0], MRS [15:0], CBZ [18:0])
- imem_we  out  1  write strobe, held until imem_ready
- imem_ready  in  1  memory accepts write this cycle
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written since reset/clear
- full  out  1  address space exhausted
- err  out  1  sticky: illegal op received

## Operation
- Encodings (bit fields MSB→LSB):
  - R-type ADD 0x458, SUB 0x658, AND 0x450, ORR 0x550: op[31:21], Rm, shamt=0, Rn, Rd.
  - BR: 0x6B0, 11111, 000000, Rn, 00000.
  - ERET: fixed 0xD69F03E0.
  - MRS: 0x6A9, imm[15:0] in [20:5], Rd in [4:0].
  - LDUR 0x7C2 / STUR 0x7C0: op, imm[8:0] in [20:12], 00, Rn, Rt=cmd_rd.
  - CBZ: 10110100, imm[18:0] in [23:5], Rt=cmd_rd.
- Unused input fields are ignored.
- FSM states and transitions:
  - IDLE: cmd_ready=1. On accept, register the word and address, go to WRITE.
  - WRITE: imem_we=1, with wdata and addr stable. On imem_ready: count+1 and addr+1.
    - If the written address was DEPTH-1 → FULL.
    - Else if cmd_valid → accept the next command back-to-back and stay in WRITE (cmd_ready = imem_ready in WRITE, except at the last address).
    - Else → IDLE.
  - FULL: cmd_ready=0, full=1. Only clear or reset exits, to IDLE.
- Address arithmetic: modulo 2^ADDR_W starting from BASE_ADDR. full asserts after DEPTH-BASE_ADDR writes. count saturates by construction (at most DEPTH).
- clear wins over everything: next state IDLE, addr=BASE_ADDR, count=0, full=0, imem_we=0 next cycle, pending word dropped, err unchanged. cmd_ready is forced 0 in the clear cycle.
- Reset mid-WRITE aborts the write. No partial state survives.

## Timing
- Reset values (held while reset=0): cmd_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, full=0, err=0, state IDLE.
- Latency: command accepted at edge t → imem_we=1 with the word during cycle t+1.
- Sustained throughput is 1 word/cycle when imem_ready stays high.
- imem_wdata and imem_addr must not change while imem_we=1 and imem_ready=0.
- full rises in the cycle after the final write handshake.

## Configuration
- LEGV8_ENC_TRAP_EN defined: an illegal op (10–15) is written as 32'h0000_0000 like any other word, so the decoder will raise NotAnInstr. err is set.
- Not defined: an illegal op is accepted and dropped (no write, no address or count change). err is set.

## Test plan
- ADD rd=1 rn=2 rm=3 → imem_wdata=0x8B030041 at addr 0, one cycle after accept; count=1.
- LDUR rd=5 rn=6 imm=8, then CBZ rd=0 imm=0x7FFFE back-to-back with imem_ready=1 → 0xF84080C5 @0, 0xB4FFFFC0 @1 on consecutive cycles.
- BR rn=30, imem_ready low 3 cycles → 0xD61F03C0 held stable with imem_we=1 and cmd_ready=0 for 3 cycles; ERET next → 0xD69F03E0.
- ADDR_W=2: issue 5 commands → 4 writes, full=1 after the 4th, 5th command not accepted; clear → count=0, addr=0, cmd_ready=1.
- cmd_op=12 → err=1. With LEGV8_ENC_TRAP_EN: 0x00000000 written. Without: no imem_we, count unchanged.
- reset=0 asserted during a stalled WRITE → next cycle imem_we=0, count=0, all outputs at reset values.
